// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake head stepper.
//   GRID_BITS / GRID_MAX : coordinate width and largest coordinate of the 32x32 grid
//   DIR_*                : direction encodings as seen on dir_in
//   state_e              : sequencing FSM states
//   is_reverse()         : true when two directions are exact opposites
package snake_pkg;

  localparam int GRID_BITS = 5;
  localparam int GRID_MAX  = 31;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_CHECK,
    ST_GROW,
    ST_DONE
  } state_e;

  // Opposite directions differ only in bit 1 (up/down, right/left).
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/adder5.sv
// adder5: 5-bit ripple-carry adder shared by the head X, head Y and length updates.
// Ports:
//   a, b : operands
//   ci   : carry in
//   s    : sum (mod 32)
//   co   : carry out of bit 4
module adder5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       ci,
  output logic [4:0] s,
  output logic       co
);

  logic [5:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 5; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[5];

endmodule

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: sequences one game step (move head, check food, grow) using a
// single time-shared 5-bit adder.
//
// Configuration macro: SNAKE_HEAD_WRAP_EN
//   defined   : moves wrap modulo 32, dead is never set
//   undefined : a move off the grid holds the head and sets the sticky dead flag
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   tick              : step request pulse (queued one-deep while busy)
//   dir_in, dir_valid : direction request (00 up, 01 right, 10 down, 11 left)
//   food_x, food_y    : food cell
//   head_x, head_y    : registered head position
//   length            : registered snake length (saturates at MAX_LEN)
//   busy              : FSM not in IDLE
//   step_done, ate    : one-cycle pulses at the end of a step
//   dead              : sticky wall-hit flag
//
// state | meaning
// IDLE  | waiting for tick or pending request
// STEP  | adder moves head one cell along dir_cur
// CHECK | compare head with food
// GROW  | adder increments length (held at MAX_LEN)
// DONE  | step_done (and ate) pulse; chain to STEP if a tick is pending
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 16,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [1:0]           dir_in,
  input  logic                 dir_valid,
  input  logic [GRID_BITS-1:0] food_x,
  input  logic [GRID_BITS-1:0] food_y,
  output logic [GRID_BITS-1:0] head_x,
  output logic [GRID_BITS-1:0] head_y,
  output logic [GRID_BITS-1:0] length,
  output logic                 busy,
  output logic                 step_done,
  output logic                 ate,
  output logic                 dead
);

  localparam logic [GRID_BITS-1:0] ONE       = GRID_BITS'(1);
  // Adding GRID_MAX (all ones) is a decrement modulo 32.
  localparam logic [GRID_BITS-1:0] MINUS_ONE = GRID_BITS'(GRID_MAX);
  localparam logic [GRID_BITS-1:0] INIT_X_V  = GRID_BITS'(INIT_X);
  localparam logic [GRID_BITS-1:0] INIT_Y_V  = GRID_BITS'(INIT_Y);
  localparam logic [GRID_BITS-1:0] INIT_L_V  = GRID_BITS'(INIT_LEN);
  localparam logic [GRID_BITS-1:0] MAX_L_V   = GRID_BITS'(MAX_LEN);

  state_e               state_q, state_d;
  logic [GRID_BITS-1:0] head_x_q, head_x_d;
  logic [GRID_BITS-1:0] head_y_q, head_y_d;
  logic [GRID_BITS-1:0] len_q, len_d;
  dir_t                 dir_cur_q, dir_cur_d;
  dir_t                 dir_next_q, dir_next_d;
  logic                 pending_q, pending_d;
  logic                 dead_q, dead_d;
  logic                 busy_q, busy_d;
  logic                 step_done_q, step_done_d;
  logic                 ate_q, ate_d;

  logic [GRID_BITS-1:0] add_a, add_b, add_s;
  logic                 add_co;
  logic                 move_x, move_inc;
  logic                 wall_hit;

  always_comb begin
    move_x   = 1'b0;
    move_inc = 1'b0;
    case (dir_cur_q)
      DIR_UP:    begin move_x = 1'b0; move_inc = 1'b0; end
      DIR_RIGHT: begin move_x = 1'b1; move_inc = 1'b1; end
      DIR_DOWN:  begin move_x = 1'b0; move_inc = 1'b1; end
      DIR_LEFT:  begin move_x = 1'b1; move_inc = 1'b0; end
    endcase
  end

  // Operand mux for the shared adder: head coordinate in STEP, length in GROW.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      ST_STEP: begin
        add_a = move_x ? head_x_q : head_y_q;
        add_b = move_inc ? ONE : MINUS_ONE;
      end
      ST_GROW: begin
        add_a = len_q;
        add_b = ONE;
      end
      default: ;
    endcase
  end

  adder5 u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

`ifdef SNAKE_HEAD_WRAP_EN
  logic unused_co;
  assign unused_co = add_co;
  assign wall_hit  = 1'b0;
`else
  // An increment off the edge carries out (31+1); a decrement off the edge is the
  // only case that does not carry out (0+31). The carry therefore flags the wall.
  assign wall_hit = move_inc ? add_co : ~add_co;
`endif

  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    len_d       = len_q;
    dir_cur_d   = dir_cur_q;
    dir_next_d  = dir_next_q;
    pending_d   = pending_q;
    dead_d      = dead_q;
    step_done_d = 1'b0;
    ate_d       = 1'b0;

    if (dir_valid && !is_reverse(dir_in, dir_cur_q)) begin
      dir_next_d = dir_in;
    end

    if (tick && (state_q != ST_IDLE) && !pending_q) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if ((tick || pending_q) && !dead_q) begin
          state_d   = ST_STEP;
          pending_d = 1'b0;
          dir_cur_d = dir_next_q;
        end
      end
      ST_STEP: begin
        if (wall_hit) begin
          dead_d      = 1'b1;
          state_d     = ST_DONE;
          step_done_d = 1'b1;
        end else begin
          if (move_x) begin
            head_x_d = add_s;
          end else begin
            head_y_d = add_s;
          end
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if ((head_x_q == food_x) && (head_y_q == food_y)) begin
          state_d = ST_GROW;
        end else begin
          state_d     = ST_DONE;
          step_done_d = 1'b1;
        end
      end
      ST_GROW: begin
        if (len_q != MAX_L_V) begin
          len_d = add_s;
        end
        state_d     = ST_DONE;
        step_done_d = 1'b1;
        ate_d       = 1'b1;
      end
      ST_DONE: begin
        if (pending_q && !dead_q) begin
          state_d   = ST_STEP;
          pending_d = 1'b0;
          dir_cur_d = dir_next_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dead_q || dead_d) begin
      pending_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      head_x_q    <= INIT_X_V;
      head_y_q    <= INIT_Y_V;
      len_q       <= INIT_L_V;
      dir_cur_q   <= DIR_RIGHT;
      dir_next_q  <= DIR_RIGHT;
      pending_q   <= 1'b0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      ate_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      len_q       <= len_d;
      dir_cur_q   <= dir_cur_d;
      dir_next_q  <= dir_next_d;
      pending_q   <= pending_d;
      dead_q      <= dead_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      ate_q       <= ate_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = len_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign ate       = ate_q;
  assign dead      = dead_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
module tb_snake_head_stepper;

  localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;

  logic       clk = 1'b0;
  logic       reset, tick, dir_valid;
  logic [1:0] dir_in;
  logic [4:0] food_x, food_y;
  logic [4:0] head_x, head_y, length;
  logic       busy, step_done, ate, dead;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         mx, my, mlen;
  logic [1:0] mcur, mnext;
  logic       mdead;
  // model expectations for the last step
  int         e_lat, e_x, e_y, e_len;
  logic       e_ate, e_dead;
  // observations from the last driven step
  int         o_lat;
  logic [4:0] o_x, o_y, o_len, o_mid_x, o_mid_y;
  logic       o_ate, o_dead, o_busy1, o_busy_after, o_sd_after;

  snake_head_stepper dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .food_x    (food_x),
    .food_y    (food_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .busy      (busy),
    .step_done (step_done),
    .ate       (ate),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit opposite(input logic [1:0] a, input logic [1:0] b);
    case (a)
      UP:      return b == DOWN;
      DOWN:    return b == UP;
      LEFT:    return b == RIGHT;
      default: return b == LEFT;
    endcase
  endfunction

  function automatic int dx(input logic [1:0] d);
    return (d == RIGHT) ? 1 : (d == LEFT) ? -1 : 0;
  endfunction

  function automatic int dy(input logic [1:0] d);
    return (d == DOWN) ? 1 : (d == UP) ? -1 : 0;
  endfunction

  function automatic bit on_grid(input int x, input int y);
    return (x >= 0) && (x <= 31) && (y >= 0) && (y <= 31);
  endfunction

  task automatic model_reset();
    mx = 16; my = 16; mlen = 3;
    mcur = RIGHT; mnext = RIGHT; mdead = 1'b0;
  endtask

  task automatic model_dir(input logic [1:0] d);
    if (!opposite(d, mcur)) mnext = d;
  endtask

  // One requested step (tick, optionally with a direction request in the same cycle).
  task automatic model_step(input bit with_dir, input logic [1:0] d);
    logic [1:0] mv;
    int nx, ny;
    e_ate = 1'b0;
    if (mdead) begin
      if (with_dir && !opposite(d, mcur)) mnext = d;
      e_lat = 0; e_x = mx; e_y = my; e_len = mlen; e_dead = 1'b1;
      return;
    end
    mv = mnext;
    if (with_dir && !opposite(d, mcur)) mnext = d;
    mcur = mv;
    nx = mx + dx(mv);
    ny = my + dy(mv);
`ifdef SNAKE_HEAD_WRAP_EN
    nx = (nx + 32) % 32;
    ny = (ny + 32) % 32;
`else
    if (!on_grid(nx, ny)) begin
      mdead = 1'b1;
      e_lat = 2; e_x = mx; e_y = my; e_len = mlen; e_dead = 1'b1;
      return;
    end
`endif
    mx = nx; my = ny;
    if (mx == int'(food_x) && my == int'(food_y)) begin
      if (mlen < 31) mlen = mlen + 1;
      e_ate = 1'b1;
      e_lat = 4;
    end else begin
      e_lat = 3;
    end
    e_x = mx; e_y = my; e_len = mlen; e_dead = mdead;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic req_dir(input logic [1:0] d);
    dir_in = d; dir_valid = 1'b1;
    cyc();
    dir_valid = 1'b0;
    model_dir(d);
  endtask

  // Issue one tick from IDLE and record what the DUT does (no checking here).
  task automatic drive_step(input bit with_dir, input logic [1:0] d);
    int c;
    tick = 1'b1; dir_valid = with_dir; dir_in = d;
    cyc();
    tick = 1'b0; dir_valid = 1'b0;
    o_busy1 = busy; o_lat = 0; c = 1;
    o_mid_x = head_x; o_mid_y = head_y;
    while (c <= 8 && o_lat == 0) begin
      if (c == 2) begin o_mid_x = head_x; o_mid_y = head_y; end
      if (step_done === 1'b1) begin
        o_lat = c;
      end else begin
        cyc();
        c++;
      end
    end
    o_x = head_x; o_y = head_y; o_len = length; o_ate = ate; o_dead = dead;
    if (o_lat != 0) cyc();
    o_busy_after = busy; o_sd_after = step_done;
  endtask

  function automatic logic [1:0] safe_dir();
    int start;
    logic [1:0] d;
    start = int'($urandom_range(0, 3));
    for (int k = 0; k < 4; k++) begin
      d = 2'((start + k) % 4);
      if (!opposite(d, mcur) && on_grid(mx + dx(d), my + dy(d))) return d;
    end
    return mcur;
  endfunction

  task automatic food_ahead();
    food_x = 5'((mx + dx(mnext) + 32) % 32);
    food_y = 5'((my + dy(mnext) + 32) % 32);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
    food_x = 5'd0; food_y = 5'd0;
    cyc(); cyc();
    reset = 1'b0;
    model_reset();
    checks++;
    if ({head_x, head_y, length} !== {5'd16, 5'd16, 5'd3}) begin
      failures++;
      $display("FAIL reset_pos got=(%0d,%0d,len %0d) exp=(16,16,len 3)", head_x, head_y, length);
    end
    checks++;
    if ({busy, step_done, ate, dead} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got busy/sd/ate/dead=%b exp=0000", {busy, step_done, ate, dead});
    end
  endtask

  task automatic test_first_step();
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if (o_busy1 !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", o_busy1); end
    checks++;
    if ({o_mid_x, o_mid_y} !== {5'(e_x), 5'(e_y)}) begin
      failures++; $display("FAIL first_head_c2 got=(%0d,%0d) exp=(%0d,%0d)", o_mid_x, o_mid_y, e_x, e_y);
    end
    checks++;
    if (o_lat !== e_lat) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", o_lat, e_lat); end
    checks++;
    if ({o_len, o_ate, o_dead} !== {5'(e_len), e_ate, e_dead}) begin
      failures++; $display("FAIL first_len_ate got=%0d/%b/%b exp=%0d/%b/%b", o_len, o_ate, o_dead, e_len, e_ate, e_dead);
    end
    checks++;
    if ({o_busy_after, o_sd_after} !== 2'b00) begin
      failures++; $display("FAIL first_after got busy/sd=%b exp=00", {o_busy_after, o_sd_after});
    end
  endtask

  task automatic test_food();
    do_reset();
    food_x = 5'd17; food_y = 5'd16;
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if (o_lat !== e_lat) begin failures++; $display("FAIL food_latency got=%0d exp=%0d", o_lat, e_lat); end
    checks++;
    if ({o_x, o_y, o_len, o_ate} !== {5'(e_x), 5'(e_y), 5'(e_len), e_ate}) begin
      failures++; $display("FAIL food_state got=(%0d,%0d) len %0d ate %b exp=(%0d,%0d) len %0d ate %b",
                           o_x, o_y, o_len, o_ate, e_x, e_y, e_len, e_ate);
    end
  endtask

  task automatic test_reverse_dir();
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    req_dir(LEFT);
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if ({o_x, o_y, o_lat} !== {5'(e_x), 5'(e_y), e_lat}) begin
      failures++; $display("FAIL reverse_dropped got=(%0d,%0d) lat %0d exp=(%0d,%0d) lat %0d", o_x, o_y, o_lat, e_x, e_y, e_lat);
    end
  endtask

  task automatic test_same_cycle_dir();
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    model_step(1'b1, DOWN);
    drive_step(1'b1, DOWN);
    checks++;
    if ({o_x, o_y} !== {5'(e_x), 5'(e_y)}) begin
      failures++; $display("FAIL samecyc_first got=(%0d,%0d) exp=(%0d,%0d)", o_x, o_y, e_x, e_y);
    end
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if ({o_x, o_y} !== {5'(e_x), 5'(e_y)}) begin
      failures++; $display("FAIL samecyc_second got=(%0d,%0d) exp=(%0d,%0d)", o_x, o_y, e_x, e_y);
    end
  endtask

  task automatic test_wall();
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    for (int i = 0; i < 15; i++) begin
      model_step(1'b0, 2'd0);
      drive_step(1'b0, 2'd0);
    end
    checks++;
    if (o_x !== 5'd31) begin failures++; $display("FAIL wall_approach got x=%0d exp=31", o_x); end
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if ({o_x, o_y, o_dead, o_ate, o_lat} !== {5'(e_x), 5'(e_y), e_dead, e_ate, e_lat}) begin
      failures++; $display("FAIL wall_step got=(%0d,%0d) dead %b ate %b lat %0d exp=(%0d,%0d) dead %b ate %b lat %0d",
                           o_x, o_y, o_dead, o_ate, o_lat, e_x, e_y, e_dead, e_ate, e_lat);
    end
    model_step(1'b0, 2'd0);
    drive_step(1'b0, 2'd0);
    checks++;
    if ({o_lat, o_busy1, o_dead} !== {e_lat, (e_lat != 0), e_dead}) begin
      failures++; $display("FAIL wall_after got lat %0d busy %b dead %b exp lat %0d dead %b", o_lat, o_busy1, o_dead, e_lat, e_dead);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, first, second, busy_low;
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    pulses = 0; first = 0; second = 0; busy_low = 0;
    tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 3) tick = 1'b0;
      if (step_done === 1'b1) begin
        pulses++;
        if (pulses == 1) first = c; else if (pulses == 2) second = c;
      end
      if (c <= 6 && busy !== 1'b1) busy_low++;
    end
    model_step(1'b0, 2'd0);
    model_step(1'b0, 2'd0);
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++;
    if ({first, second} != {32'd3, 32'd6}) begin
      failures++; $display("FAIL b2b_timing got=%0d,%0d exp=3,6", first, second);
    end
    checks++;
    if (busy_low != 0) begin failures++; $display("FAIL b2b_busy got low_cycles=%0d exp=0", busy_low); end
    checks++;
    if ({head_x, head_y} !== {5'(mx), 5'(my)}) begin
      failures++; $display("FAIL b2b_head got=(%0d,%0d) exp=(%0d,%0d)", head_x, head_y, mx, my);
    end
  endtask

  task automatic test_saturation_and_reset();
    int guard;
    do_reset();
    guard = 0;
    while ((mlen < 31 || guard < 29) && guard < 40) begin
      req_dir(safe_dir());
      food_ahead();
      model_step(1'b0, 2'd0);
      drive_step(1'b0, 2'd0);
      checks++;
      if ({o_lat, o_x, o_y, o_len, o_ate, o_dead} !== {e_lat, 5'(e_x), 5'(e_y), 5'(e_len), e_ate, e_dead}) begin
        failures++; $display("FAIL grow_step%0d got lat %0d (%0d,%0d) len %0d ate %b exp lat %0d (%0d,%0d) len %0d ate %b",
                             guard, o_lat, o_x, o_y, o_len, o_ate, e_lat, e_x, e_y, e_len, e_ate);
      end
      guard++;
    end
    checks++;
    if ({length, o_ate} !== {5'd31, 1'b1}) begin
      failures++; $display("FAIL sat_len got len %0d ate %b exp len 31 ate 1", length, o_ate);
    end
    req_dir(safe_dir());
    food_ahead();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_reset();
    checks++;
    if ({head_x, head_y, length, busy, step_done, ate, dead} !== {5'd16, 5'd16, 5'd3, 4'b0000}) begin
      failures++; $display("FAIL reset_in_grow got=(%0d,%0d) len %0d flags %b exp=(16,16) len 3 flags 0000",
                           head_x, head_y, length, {busy, step_done, ate, dead});
    end
  endtask

  task automatic test_random();
    bit wd;
    logic [1:0] d;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      wd = 1'b0;
      d = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: req_dir(d);
        1: wd = 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) food_ahead();
      else begin food_x = 5'($urandom_range(0, 31)); food_y = 5'($urandom_range(0, 31)); end
      model_step(wd, d);
      drive_step(wd, d);
      checks++;
      if ({o_lat, o_x, o_y, o_len, o_ate, o_dead} !== {e_lat, 5'(e_x), 5'(e_y), 5'(e_len), e_ate, e_dead}) begin
        failures++; $display("FAIL rand_step%0d got lat %0d (%0d,%0d) len %0d ate %b dead %b exp lat %0d (%0d,%0d) len %0d ate %b dead %b",
                             i, o_lat, o_x, o_y, o_len, o_ate, o_dead, e_lat, e_x, e_y, e_len, e_ate, e_dead);
      end
      if (mdead && $urandom_range(0, 2) == 0) do_reset();
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
    food_x = 5'd0; food_y = 5'd0;
    test_reset();
    test_first_step();
    test_food();
    test_reverse_dir();
    test_same_cycle_dir();
    test_wall();
    test_back_to_back();
    test_saturation_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
